// File: rtl/highscore_manager_pkg.sv
// highscore_manager_pkg
//   Shared constants and types for the high-score block.
//   - BUTTON_* : bit positions inside the 8-bit one-pulse button bus
//   - CHAR_A / CHAR_SPACE : first / last selectable character codes
//   - CHAR_SIZE / SCORE_SIZE : default character and score widths
//   - hs_phase_t : control phases of the high-score flow
package highscore_manager_pkg;

   localparam int BUTTON_UP    = 0;
   localparam int BUTTON_DOWN  = 1;
   localparam int BUTTON_LEFT  = 2;
   localparam int BUTTON_RIGHT = 3;

   localparam int CHAR_SIZE  = 5;
   localparam int SCORE_SIZE = 16;
   localparam int CHAR_A     = 0;
   localparam int CHAR_SPACE = 26;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      NAMING,
      INSERT,
      DISPLAY
   } hs_phase_t;

endpackage

// File: rtl/highscore_manager_keypad.sv
// name_entry_keypad
//   Edits a NAME_LEN-character name with the four direction buttons.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     clear           forces all characters to CHAR_MIN and cursor to 0
//     active          enables editing
//     event_onepulse  one-cycle button pulses (BUTTON_* positions)
//     name_entry      char j at [j*CHAR_SIZE +: CHAR_SIZE], j=0 leftmost
//     cursor          edit position; NAME_LEN is the confirm slot
//     confirm         combinational one-cycle confirm strobe
module name_entry_keypad #(
   parameter int NAME_LEN  = 3,
   parameter int CHAR_SIZE = highscore_manager_pkg::CHAR_SIZE,
   parameter int CHAR_MIN  = highscore_manager_pkg::CHAR_A,
   parameter int CHAR_MAX  = highscore_manager_pkg::CHAR_SPACE,
   localparam int CW       = $clog2(NAME_LEN + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          active,
   input  logic [7:0]                    event_onepulse,
   output logic [NAME_LEN*CHAR_SIZE-1:0] name_entry,
   output logic [CW-1:0]                 cursor,
   output logic                          confirm
);
   import highscore_manager_pkg::BUTTON_UP;
   import highscore_manager_pkg::BUTTON_DOWN;
   import highscore_manager_pkg::BUTTON_LEFT;
   import highscore_manager_pkg::BUTTON_RIGHT;

   localparam logic [CHAR_SIZE-1:0] C_MIN    = CHAR_SIZE'(CHAR_MIN);
   localparam logic [CHAR_SIZE-1:0] C_MAX    = CHAR_SIZE'(CHAR_MAX);
   localparam logic [CW-1:0]        CUR_LAST = CW'(NAME_LEN);
   // Any button except LEFT/RIGHT confirms while on the confirm slot.
   localparam logic [7:0] CONFIRM_MASK =
      ~((8'd1 << BUTTON_LEFT) | (8'd1 << BUTTON_RIGHT));

   logic [CHAR_SIZE-1:0] chars_q [NAME_LEN];
   logic                 at_confirm;
   logic                 btn_up, btn_down, btn_left, btn_right;

   assign btn_up     = event_onepulse[BUTTON_UP];
   assign btn_down   = event_onepulse[BUTTON_DOWN];
   assign btn_left   = event_onepulse[BUTTON_LEFT];
   assign btn_right  = event_onepulse[BUTTON_RIGHT];
   assign at_confirm = (cursor == CUR_LAST);
   assign confirm    = active && at_confirm && |(event_onepulse & CONFIRM_MASK);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      name_entry = '0;
      for (int j = 0; j < NAME_LEN; j++) name_entry[j*CHAR_SIZE +: CHAR_SIZE] = chars_q[j];
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int j = 0; j < NAME_LEN; j++) chars_q[j] <= C_MIN;
         cursor <= '0;
      end else if (active && !confirm) begin
         // Priority UP > DOWN > LEFT > RIGHT, one action per cycle.
         if (btn_up || btn_down) begin
            for (int j = 0; j < NAME_LEN; j++) begin
               if (cursor == CW'(j)) begin
                  if (btn_up)
                     chars_q[j] <= (chars_q[j] == C_MAX) ? C_MIN : chars_q[j] + CHAR_SIZE'(1);
                  else
                     chars_q[j] <= (chars_q[j] == C_MIN) ? C_MAX : chars_q[j] - CHAR_SIZE'(1);
               end
            end
         end else if (btn_left) begin
            cursor <= (cursor == '0) ? CUR_LAST : cursor - CW'(1);
         end else if (btn_right) begin
            cursor <= at_confirm ? '0 : cursor + CW'(1);
         end
      end
   end

endmodule

// File: rtl/highscore_manager.sv
// highscore_manager
//   Owns a sorted ENTRIES-deep high-score table; checks a finished game's
//   score, lets the player enter a name, and performs a multi-cycle sorted
//   insert (new score placed below equal existing scores).
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     en              high while in the scoreboard scene
//     event_onepulse  one-cycle button pulses
//     new_score       final score of the finished game
//     done / busy     high in DISPLAY / INSERT
//     qualifies       result of the qualification check
//     rank            slot of the last insert; ENTRIES = not placed
//     cursor, name_entry            name editor state
//     table_scores, table_names     flattened table, entry 0 highest
module highscore_manager #(
   parameter int ENTRIES    = 5,
   parameter int NAME_LEN   = 3,
   parameter int SCORE_SIZE = highscore_manager_pkg::SCORE_SIZE,
   parameter int CHAR_SIZE  = highscore_manager_pkg::CHAR_SIZE,
   parameter int CHAR_MIN   = highscore_manager_pkg::CHAR_A,
   parameter int CHAR_MAX   = highscore_manager_pkg::CHAR_SPACE,
   localparam int RW        = $clog2(ENTRIES + 1),
   localparam int CW        = $clog2(NAME_LEN + 1),
   localparam int NW        = NAME_LEN * CHAR_SIZE
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic [7:0]                      event_onepulse,
   input  logic [SCORE_SIZE-1:0]           new_score,
   output logic                            done,
   output logic                            busy,
   output logic                            qualifies,
   output logic [RW-1:0]                   rank,
   output logic [CW-1:0]                   cursor,
   output logic [NW-1:0]                   name_entry,
   output logic [ENTRIES*SCORE_SIZE-1:0]   table_scores,
   output logic [ENTRIES*NW-1:0]           table_names
);
   import highscore_manager_pkg::hs_phase_t;
   import highscore_manager_pkg::IDLE;
   import highscore_manager_pkg::CHECK;
   import highscore_manager_pkg::NAMING;
   import highscore_manager_pkg::INSERT;
   import highscore_manager_pkg::DISPLAY;

   localparam logic [RW-1:0] NOT_PLACED = RW'(ENTRIES);
   localparam logic [RW-1:0] LAST_IDX   = RW'(ENTRIES - 1);

   hs_phase_t             state_q;
   logic [SCORE_SIZE-1:0] score_q;
   logic [RW-1:0]         idx_q;
   logic [SCORE_SIZE-1:0] scores_q [ENTRIES];
   logic [NW-1:0]         names_q  [ENTRIES];
   logic                  confirm;

   name_entry_keypad #(
      .NAME_LEN (NAME_LEN),
      .CHAR_SIZE(CHAR_SIZE),
      .CHAR_MIN (CHAR_MIN),
      .CHAR_MAX (CHAR_MAX)
   ) u_keypad (
      .clk           (clk),
      .rst           (rst),
      .clear         (state_q == IDLE),
      .active        (state_q == NAMING),
      .event_onepulse(event_onepulse),
      .name_entry    (name_entry),
      .cursor        (cursor),
      .confirm       (confirm)
   );

   always_comb begin
      table_scores = '0;
      table_names  = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         table_scores[i*SCORE_SIZE +: SCORE_SIZE] = scores_q[i];
         table_names[i*NW +: NW]                  = names_q[i];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         score_q   <= '0;
         idx_q     <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         qualifies <= 1'b0;
         rank      <= NOT_PLACED;
         // NOTE: the table is a register array, not RAM, because reset must visibly clear every entry.
         for (int i = 0; i < ENTRIES; i++) begin
            scores_q[i] <= '0;
            names_q[i]  <= {NAME_LEN{CHAR_SIZE'(CHAR_MAX)}};
         end
      end else begin
         case (state_q)
            IDLE: if (en) state_q <= CHECK;
            CHECK: begin
               score_q   <= new_score;
               qualifies <= (new_score > scores_q[ENTRIES-1]);
               if (!en) begin
                  state_q <= IDLE;
               end else if (new_score > scores_q[ENTRIES-1]) begin
                  state_q <= NAMING;
               end else begin
                  rank    <= NOT_PLACED;
                  done    <= 1'b1;
                  state_q <= DISPLAY;
               end
            end
            NAMING: begin
               if (!en) begin
                  state_q <= IDLE;
               end else if (confirm) begin
                  idx_q   <= LAST_IDX;
                  busy    <= 1'b1;
                  state_q <= INSERT;
               end
            end
            INSERT: begin
               // Bubble the hole upward while the entry above is strictly lower.
               if (idx_q != '0 && scores_q[idx_q - RW'(1)] < score_q) begin
                  scores_q[idx_q] <= scores_q[idx_q - RW'(1)];
                  names_q[idx_q]  <= names_q[idx_q - RW'(1)];
                  idx_q           <= idx_q - RW'(1);
               end else begin
                  scores_q[idx_q] <= score_q;
                  names_q[idx_q]  <= name_entry;
                  rank            <= idx_q;
                  busy            <= 1'b0;
                  done            <= 1'b1;
                  state_q         <= DISPLAY;
               end
            end
            DISPLAY: begin
               if (!en) begin
                  done    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_highscore_manager.sv
module tb_highscore_manager;

   localparam int E  = 5;
   localparam int NL = 3;
   localparam int SS = 16;
   localparam int CS = 5;
   localparam int NW = NL * CS;

   localparam logic [7:0] UP    = 8'd1 << highscore_manager_pkg::BUTTON_UP;
   localparam logic [7:0] DOWN  = 8'd1 << highscore_manager_pkg::BUTTON_DOWN;
   localparam logic [7:0] LEFT  = 8'd1 << highscore_manager_pkg::BUTTON_LEFT;
   localparam logic [7:0] RIGHT = 8'd1 << highscore_manager_pkg::BUTTON_RIGHT;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic [7:0]        event_onepulse = '0;
   logic [SS-1:0]     new_score = '0;
   logic              done, busy, qualifies;
   logic [2:0]        rank;
   logic [1:0]        cursor;
   logic [NW-1:0]     name_entry;
   logic [E*SS-1:0]   table_scores;
   logic [E*NW-1:0]   table_names;

   int n_cmp = 0;
   int n_bad = 0;

   highscore_manager dut (
      .clk(clk), .rst(rst), .en(en), .event_onepulse(event_onepulse),
      .new_score(new_score), .done(done), .busy(busy), .qualifies(qualifies),
      .rank(rank), .cursor(cursor), .name_entry(name_entry),
      .table_scores(table_scores), .table_names(table_names)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] ev);
      event_onepulse = ev;
      tick();
      event_onepulse = '0;
   endtask

   function automatic logic [E*SS-1:0] pack_scores(input int a, b, c, d, f);
      pack_scores = {SS'(f), SS'(d), SS'(c), SS'(b), SS'(a)};
   endfunction

   function automatic logic [NW-1:0] pack_name(input int a, b, c);
      pack_name = {CS'(c), CS'(b), CS'(a)};
   endfunction

   function automatic logic [E*NW-1:0] reset_names();
      logic [E*NW-1:0] r;
      for (int k = 0; k < E * NL; k++) r[k*CS +: CS] = CS'(26);
      return r;
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, " scores"}, table_scores, '0);
      check({tag, " names"}, table_names, reset_names());
      check({tag, " rank"}, rank, 3'd5);
      check({tag, " done"}, done, 1'b0);
      check({tag, " busy"}, busy, 1'b0);
      check({tag, " qualifies"}, qualifies, 1'b0);
   endtask

   typedef struct {
      bit              do_rst;
      int              score;
      logic [NW-1:0]   name;
      bit              exp_q;
      int              exp_rank;
      int              exp_busy;
      logic [E*SS-1:0] exp_scores;
      int              chk_e;
      logic [NW-1:0]   chk_name;
   } vec_t;

   vec_t vecs [14];

   initial begin
      int n;
      // Table-driven games: each row is one full visit to the scoreboard scene.
      vecs[0]  = '{1, 0,   pack_name(0,0,0), 0, 5, 0, pack_scores(0,0,0,0,0),           -1, '0};
      vecs[1]  = '{0, 100, pack_name(1,0,0), 1, 0, 5, pack_scores(100,0,0,0,0),         -1, '0};
      vecs[2]  = '{0, 200, pack_name(2,0,0), 1, 0, 5, pack_scores(200,100,0,0,0),       -1, '0};
      vecs[3]  = '{0, 300, pack_name(3,0,0), 1, 0, 5, pack_scores(300,200,100,0,0),     -1, '0};
      vecs[4]  = '{0, 400, pack_name(4,0,0), 1, 0, 5, pack_scores(400,300,200,100,0),   -1, '0};
      vecs[5]  = '{0, 500, pack_name(5,0,0), 1, 0, 5, pack_scores(500,400,300,200,100), 0, pack_name(5,0,0)};
      vecs[6]  = '{0, 100, pack_name(0,0,0), 0, 5, 0, pack_scores(500,400,300,200,100), 4, pack_name(1,0,0)};
      vecs[7]  = '{0, 300, pack_name(1,2,3), 1, 3, 2, pack_scores(500,400,300,300,200), 3, pack_name(1,2,3)};
      vecs[8]  = '{1, 100, pack_name(1,0,0), 1, 0, 5, pack_scores(100,0,0,0,0),         -1, '0};
      vecs[9]  = '{0, 200, pack_name(2,0,0), 1, 0, 5, pack_scores(200,100,0,0,0),       -1, '0};
      vecs[10] = '{0, 300, pack_name(3,0,0), 1, 0, 5, pack_scores(300,200,100,0,0),     -1, '0};
      vecs[11] = '{0, 400, pack_name(4,0,0), 1, 0, 5, pack_scores(400,300,200,100,0),   -1, '0};
      vecs[12] = '{0, 500, pack_name(5,0,0), 1, 0, 5, pack_scores(500,400,300,200,100), -1, '0};
      vecs[13] = '{0, 600, pack_name(7,8,9), 1, 0, 5, pack_scores(600,500,400,300,200), 1, pack_name(5,0,0)};

      tick();
      tick();
      rst = 1'b0;

      for (int v = 0; v < 14; v++) begin
         if (vecs[v].do_rst) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check_reset_state($sformatf("v%0d reset", v));
            check($sformatf("v%0d reset name_entry", v), name_entry, '0);
            check($sformatf("v%0d reset cursor", v), cursor, '0);
         end
         new_score = SS'(vecs[v].score);
         en = 1'b1;
         tick();
         tick();
         check($sformatf("v%0d qualifies", v), qualifies, vecs[v].exp_q);
         if (vecs[v].exp_q) begin
            for (int j = 0; j < NL; j++) begin
               repeat (int'(vecs[v].name[j*CS +: CS])) pulse(UP);
               pulse(RIGHT);
            end
            check($sformatf("v%0d name_entry", v), name_entry, vecs[v].name);
            check($sformatf("v%0d cursor", v), cursor, 2'd3);
            pulse(UP);
         end
         n = 0;
         while (busy && n < 20) begin
            n++;
            tick();
         end
         check($sformatf("v%0d busy cycles", v), n, vecs[v].exp_busy);
         check($sformatf("v%0d done", v), done, 1'b1);
         check($sformatf("v%0d rank", v), rank, vecs[v].exp_rank);
         check($sformatf("v%0d scores", v), table_scores, vecs[v].exp_scores);
         if (vecs[v].chk_e >= 0)
            check($sformatf("v%0d name of entry %0d", v, vecs[v].chk_e),
                  table_names[vecs[v].chk_e*NW +: NW], vecs[v].chk_name);
         en = 1'b0;
         tick();
         check($sformatf("v%0d done after leave", v), done, 1'b0);
      end

      check("final entry0 name", table_names[0*NW +: NW], pack_name(7,8,9));
      check("final entry4 name", table_names[4*NW +: NW], pack_name(2,0,0));

      // Keypad wrap and priority, then leave the scene while naming.
      new_score = 16'd1000;
      en = 1'b1;
      tick();
      tick();
      check("wrap qualifies", qualifies, 1'b1);
      pulse(DOWN);
      check("wrap down char0", name_entry[0 +: CS], 5'd26);
      pulse(UP);
      check("wrap up char0", name_entry[0 +: CS], 5'd0);
      pulse(LEFT);
      check("wrap left cursor", cursor, 2'd3);
      pulse(RIGHT);
      check("wrap right cursor", cursor, 2'd0);
      pulse(UP | LEFT);
      check("up+left char0", name_entry[0 +: CS], 5'd1);
      check("up+left cursor", cursor, 2'd0);
      en = 1'b0;
      tick();
      check("abort naming busy", busy, 1'b0);
      check("abort naming done", done, 1'b0);
      check("abort naming scores", table_scores, pack_scores(600,500,400,300,200));
      tick();
      check("idle clears name", name_entry, '0);
      check("idle clears cursor", cursor, 2'd0);

      // en drops on the first INSERT cycle: insert still completes.
      new_score = 16'd450;
      en = 1'b1;
      tick();
      tick();
      pulse(LEFT);
      pulse(UP);
      check("late abort busy start", busy, 1'b1);
      en = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         n++;
         tick();
      end
      check("late abort busy cycles", n, 3);
      check("late abort done", done, 1'b1);
      check("late abort rank", rank, 3'd2);
      check("late abort scores", table_scores, pack_scores(600,500,450,400,300));
      check("late abort entry2 name", table_names[2*NW +: NW], pack_name(0,0,0));
      check("late abort entry3 name", table_names[3*NW +: NW], pack_name(4,0,0));
      tick();
      check("late abort back to idle", done, 1'b0);

      // Reset on the second INSERT cycle.
      new_score = 16'd700;
      en = 1'b1;
      tick();
      tick();
      pulse(LEFT);
      pulse(UP);
      tick();
      check("mid insert busy", busy, 1'b1);
      rst = 1'b1;
      en = 1'b0;
      tick();
      rst = 1'b0;
      check_reset_state("mid insert reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
